alu_ctrl: RTL
=============

# alu_ctrl

Sequencing front end for the team's 4-bit combinational ALU (ports A, B, F, Y). Accepts commands over a valid/ready handshake and holds four 4-bit operand registers. For each command it drives the ALU with registered operands and opcode, captures Y one cycle later, and writes the result back to the register file. It sits between the board-level command source (switches/UART decoder) and the ALU instance, which stays external and purely combinational.

## Interface
- NREGS, 4: number of 4-bit registers (fixed at 4; index width 2)
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_load  in  1  1 = load immediate, 0 = ALU operation
- cmd_f  in  3  ALU opcode (ALU operation only)
- cmd_sa  in  2  source register for A
- cmd_sb  in  2  source register for B
- cmd_dst  in  2  destination register
- cmd_imm  in  4  immediate data (load only)
- alu_a  out  4  registered A operand to ALU
- alu_b  out  4  registered B operand to ALU
- alu_f  out  3  registered opcode to ALU
- alu_y  in  4  ALU result, combinational from alu_a/alu_b/alu_f
- res_valid  out  1  one-cycle pulse: result written
- res_data  out  4  result written back
- res_zero  out  1  res_data == 0
- rd_addr  in  2  debug read address
- rd_data  out  4  register[rd_addr], combinational

## Operation
- Opcode set is fixed by the ALU: 000 A&B, 001 A|B, 010 A+B, 011 A>B, 100 A&~B, 101 A|~B, 110 A−B, 111 A==B.
- Compare results are 0001 (true) or 0000 (false). Add and subtract wrap modulo 16; carry/borrow is discarded.
- FSM states:
  - IDLE: cmd_ready=1.
  - ISSUE: ALU operands stable.
  - WB: result visible.
- IDLE, accepted ALU command (cmd_valid&cmd_ready): latch regs[cmd_sa]→alu_a, regs[cmd_sb]→alu_b, cmd_f→alu_f, cmd_dst→dst register; go to ISSUE.
- IDLE, accepted load: regs[cmd_dst]←cmd_imm and res_data←cmd_imm; go to WB.
- ISSUE → WB unconditionally: regs[dst]←alu_y, res_data←alu_y.
- WB → IDLE unconditionally. res_valid=1 only in WB. res_zero = (res_data==0).
- cmd_ready=0 in ISSUE and WB. cmd_valid is ignored while busy, and no command is queued.
- Operands are sampled at acceptance. Therefore:
  - cmd_sa==cmd_sb is legal.
  - dst equal to a source is legal and overwrites only at the WB entry edge.
- alu_a/alu_b/alu_f hold their last values outside ISSUE.
- rd_data reflects register contents as of the last edge. A write becomes visible in the cycle after its edge.

## Timing
- Reset (rst=0 sampled at an edge):
  - State → IDLE; all registers = 0.
  - alu_a = alu_b = 0; alu_f = 000.
  - res_valid = 0; res_data = 0; res_zero = 1.
  - cmd_ready = 1 in the first cycle after the reset edge.
- Reset mid-operation (ISSUE or WB) aborts the command: no writeback, and res_valid=0 in the next cycle.
- ALU command accepted at edge k:
  - Cycle k..k+1: ISSUE.
  - Edge k+1: writeback.
  - Cycle k+1..k+2: res_valid=1.
  - Cycle after edge k+2: cmd_ready=1.
  - Throughput is 1 command per 3 cycles.
- Load accepted at edge k: writeback at edge k, res_valid=1 during cycle k..k+1, cmd_ready=1 after edge k+1. Throughput is 1 per 2 cycles.
- cmd_valid may be held high continuously. Each IDLE cycle with cmd_valid=1 accepts exactly one command.
- ALU combinational path: alu_a/alu_b/alu_f → alu_y must settle within one clock period.

## Test plan
- Reset then idle:
  - Stimulus: rst=0 for 2 cycles, then rst=1.
  - Response: cmd_ready=1, res_zero=1, rd_data=0 for rd_addr 0..3, res_valid never asserted.
- Loads then add:
  - Stimulus: load r0=7, load r1=5, then F=010 sa=0 sb=1 dst=2.
  - Response: res_valid pulse with res_data=1100 exactly 2 cycles after acceptance; rd_data(r2)=1100.
- Subtract wrap and zero flag:
  - Stimulus: r0=3, r1=5, F=110 → r3.
  - Response: res_data=1110.
  - Stimulus: F=110 with sa=sb=0.
  - Response: res_data=0000, res_zero=1.
- Compares and in-place write:
  - Stimulus: r0=9, r1=4; F=011 sa=0 sb=1 dst=0.
  - Response: r0=0001, and alu_a during ISSUE shows the old value 1001.
  - Stimulus: F=111 on equal registers.
  - Response: 0001.
- Back-to-back with cmd_valid held high:
  - Stimulus: four commands presented back to back.
  - Response: acceptances exactly 3 cycles apart, cmd_ready=0 in ISSUE/WB, four res_valid pulses, no command dropped or duplicated.
- Reset mid-operation:
  - Stimulus: load r2=1111; issue A|B with dst=2; assert rst in the ISSUE cycle.
  - Response: no res_valid, r2 reads 0 after reset, cmd_ready=1 on the next cycle.

Source files
------------

// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer and 4x4-bit register file in front of an
// external combinational 4-bit ALU (operands registered, result written back).
module alu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_f,
    input  logic [1:0] cmd_sa,
    input  logic [1:0] cmd_sb,
    input  logic [1:0] cmd_dst,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_f,
    input  logic [3:0] alu_y,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic       res_zero,
    input  logic [1:0] rd_addr,
    output logic [3:0] rd_data
);

    localparam int NREGS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] regs [NREGS];
    logic [1:0] dst;

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == WB);
    assign res_zero  = (res_data == 4'd0);
    assign rd_data   = regs[rd_addr];

    // Sources are sampled at acceptance, so dst may alias a source safely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_f    <= 3'd0;
            dst      <= 2'd0;
            res_data <= 4'd0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 4'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            regs[cmd_dst] <= cmd_imm;
                            res_data      <= cmd_imm;
                            state         <= WB;
                        end else begin
                            alu_a <= regs[cmd_sa];
                            alu_b <= regs[cmd_sb];
                            alu_f <= cmd_f;
                            dst   <= cmd_dst;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    regs[dst] <= alu_y;
                    res_data  <= alu_y;
                    state     <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
